// File: rtl/sdram_wr_buf_if.sv
// Handshake bundle between the user write stream, the write buffer and the SDRAM write engine.
interface sdram_wr_buf_if;
   logic        usr_wr_valid;
   logic        usr_wr_ready;
   logic [15:0] usr_wr_data;
   logic        wr_en;
   logic [23:0] wr_addr;
   logic [9:0]  wr_bst_len;
   logic [15:0] wr_data;
   logic        wr_ack;
   logic        wr_end;

   modport master (
      output usr_wr_valid, usr_wr_data, wr_ack, wr_end,
      input  usr_wr_ready, wr_en, wr_addr, wr_bst_len, wr_data
   );

   modport slave (
      input  usr_wr_valid, usr_wr_data, wr_ack, wr_end,
      output usr_wr_ready, wr_en, wr_addr, wr_bst_len, wr_data
   );
endinterface

// File: rtl/sdram_wr_buf.sv
// SDRAM write feeder: FIFO-buffers a 16-bit user stream and requests one fixed-length
// burst at a time from the write engine, advancing a wrapping linear word address.
module sdram_wr_buf #(
   parameter int unsigned FIFO_DEPTH = 1024,
   parameter int unsigned BST_LEN    = 256,
   parameter logic [23:0] ADDR_BASE  = 24'h000000,
   parameter logic [23:0] ADDR_END   = 24'hFFFFFF,
   localparam int unsigned PW        = $clog2(FIFO_DEPTH),
   localparam int unsigned LW        = PW + 1
) (
   input  logic          wb_clk,
   input  logic          wb_rst,
   sdram_wr_buf_if.slave bus,
   input  logic          addr_clr,
   input  logic          init_end,
   output logic [LW-1:0] fifo_level,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] BST_L   = LW'(BST_LEN);
   localparam logic [9:0]    BST_CNT = 10'(BST_LEN);
   localparam logic [24:0]   BST_A   = 25'(BST_LEN);

   logic [15:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [15:0]   wr_data_q, wr_data_d;
   logic [23:0]   wr_addr_q, wr_addr_d;
   logic [9:0]    ack_cnt_q, ack_cnt_d;
   logic          wr_en_q, wr_en_d;
   logic          err_q, err_d;
   logic          clr_pend_q, clr_pend_d;
   state_t        state_q, state_d;

   logic          push, pop, clr_now;
   logic [24:0]   nxt_addr;
   logic [23:0]   adv_addr;

   assign bus.usr_wr_ready = (level_q < DEPTH_L);
   assign push             = bus.usr_wr_valid & bus.usr_wr_ready;
   assign pop              = bus.wr_ack & (level_q != '0);
   assign clr_now          = clr_pend_q | addr_clr;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      wr_data_d  = wr_data_q;
      wr_addr_d  = wr_addr_q;
      ack_cnt_d  = ack_cnt_q;
      wr_en_d    = wr_en_q;
      err_d      = err_q;
      clr_pend_d = clr_now;
      state_d    = state_q;

      // The next burst must fit entirely below ADDR_END, otherwise restart at the base.
      nxt_addr = {1'b0, wr_addr_q} + BST_A;
      adv_addr = (nxt_addr + BST_A - 25'd1 > {1'b0, ADDR_END}) ? ADDR_BASE : nxt_addr[23:0];

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
         wr_data_d = mem[rd_ptr_q];
         rd_ptr_d  = rd_ptr_q + 1'b1;
      end
      level_d = level_q + LW'(push) - LW'(pop);
      if (bus.wr_ack && level_q == '0) err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (bus.wr_ack || bus.wr_end) err_d = 1'b1;
            if (clr_now) begin
               wr_addr_d  = ADDR_BASE;
               clr_pend_d = 1'b0;
            end
            if (init_end && level_q >= BST_L) begin
               wr_en_d = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.wr_end) err_d = 1'b1;
            if (bus.wr_ack) begin
               wr_en_d   = 1'b0;
               ack_cnt_d = 10'd1;
               state_d   = BURST;
            end
         end
         BURST: begin
            if (bus.wr_ack) begin
               if (ack_cnt_q >= BST_CNT) err_d = 1'b1;
               else                      ack_cnt_d = ack_cnt_q + 10'd1;
            end
            if (bus.wr_end) begin
               if (ack_cnt_d != BST_CNT) err_d = 1'b1;
               wr_addr_d  = clr_now ? ADDR_BASE : adv_addr;
               clr_pend_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         wr_data_q  <= '0;
         wr_addr_q  <= ADDR_BASE;
         ack_cnt_q  <= '0;
         wr_en_q    <= 1'b0;
         err_q      <= 1'b0;
         clr_pend_q <= 1'b0;
         state_q    <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         wr_data_q  <= wr_data_d;
         wr_addr_q  <= wr_addr_d;
         ack_cnt_q  <= ack_cnt_d;
         wr_en_q    <= wr_en_d;
         err_q      <= err_d;
         clr_pend_q <= clr_pend_d;
         state_q    <= state_d;
      end
   end

   // NOTE: the storage array has no reset; the pointers and level define what is valid.
   always_ff @(posedge wb_clk) begin
      if (push) mem[wr_ptr_q] <= bus.usr_wr_data;
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_bst_len = BST_CNT;
   assign bus.wr_data    = wr_data_q;
   assign fifo_level     = level_q;
   assign err            = err_q;

endmodule

// File: tb/tb_sdram_wr_buf.sv
// Scoreboard bench for sdram_wr_buf: a queue model of the FIFO and burst address sequence
// produces expected words/addresses; a negedge monitor compares whatever the DUT presents.
module tb_sdram_wr_buf;
   localparam int unsigned FIFO_DEPTH = 1024;
   localparam int unsigned BST_LEN    = 256;
   localparam logic [23:0] ADDR_BASE  = 24'h000000;
   localparam logic [23:0] ADDR_END   = 24'h0003FF;

   logic        wb_clk = 1'b0;
   logic        wb_rst = 1'b1;
   logic        addr_clr = 1'b0;
   logic        init_end = 1'b0;
   logic [10:0] fifo_level;
   logic        err;

   sdram_wr_buf_if bus();

   sdram_wr_buf #(
      .FIFO_DEPTH(FIFO_DEPTH), .BST_LEN(BST_LEN), .ADDR_BASE(ADDR_BASE), .ADDR_END(ADDR_END)
   ) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .bus(bus.slave), .addr_clr(addr_clr),
      .init_end(init_end), .fifo_level(fifo_level), .err(err)
   );

   always #5 wb_clk = ~wb_clk;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [15:0] mq[$];
   logic [15:0] exp_data[$];
   logic [23:0] exp_addr[$];
   logic [23:0] model_addr = ADDR_BASE;
   logic [23:0] burst_addr = ADDR_BASE;
   bit          model_busy = 1'b0;
   bit          model_clr  = 1'b0;
   bit          pop_flag   = 1'b0;
   bit          pop_seen   = 1'b0;
   bit          prev_en    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Burst address rule: the following burst must fit below ADDR_END, else restart at base.
   function automatic logic [23:0] next_addr(input logic [23:0] a);
      longint unsigned n;
      n = a;
      n = n + BST_LEN;
      if (n + BST_LEN - 1 > ADDR_END) return ADDR_BASE;
      return n[23:0];
   endfunction

   // A request is due whenever no burst is in flight, init is done and a full burst is buffered.
   task automatic model_maybe_req();
      if (!model_busy && init_end && mq.size() >= BST_LEN) begin
         exp_addr.push_back(model_addr);
         burst_addr = model_addr;
         model_busy = 1'b1;
      end
   endtask

   task automatic cycle(input bit v, input logic [15:0] d, input bit ack, input bit endp, input bit clr);
      bit push_ok;
      bus.usr_wr_valid = v;
      bus.usr_wr_data  = d;
      bus.wr_ack       = ack;
      bus.wr_end       = endp;
      addr_clr         = clr;
      push_ok  = v && (mq.size() < FIFO_DEPTH);
      pop_flag = ack && (mq.size() > 0);
      if (pop_flag) exp_data.push_back(mq.pop_front());
      if (push_ok) mq.push_back(d);
      if (clr) begin
         if (model_busy) model_clr = 1'b1;
         else            model_addr = ADDR_BASE;
      end
      @(posedge wb_clk);
      #1;
      bus.usr_wr_valid = 1'b0;
      bus.wr_ack       = 1'b0;
      bus.wr_end       = 1'b0;
      addr_clr         = 1'b0;
      pop_flag         = 1'b0;
      model_maybe_req();
   endtask

   task automatic wait_req();
      int i;
      i = 0;
      while (!bus.wr_en && i < 40) begin
         cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
         i++;
      end
      check("req_seen", 32'(bus.wr_en), 32'd1);
   endtask

   // push_mode: 0 none, 1 random pushes, 2 push on every ack cycle. clr_at: ack index for addr_clr.
   task automatic do_burst(input int n_acks, input int push_mode, input int clr_at);
      int acks;
      bit a, p;
      wait_req();
      acks = 0;
      while (acks < n_acks) begin
         a = ($urandom_range(0, 3) != 0);
         p = (push_mode == 2) ? a : (push_mode == 1 && $urandom_range(0, 1) == 1);
         cycle(p, 16'($urandom), a, 1'b0, a && (acks == clr_at));
         if (a) acks++;
      end
      if (clr_at >= 0) check("addr_hold", 32'(bus.wr_addr), 32'(burst_addr));
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      model_busy = 1'b0;
      model_addr = model_clr ? ADDR_BASE : next_addr(model_addr);
      model_clr  = 1'b0;
      check("wr_en_low", 32'(bus.wr_en), 32'd0);
      check("addr_adv", 32'(bus.wr_addr), 32'(model_addr));
      model_maybe_req();
   endtask

   always @(posedge wb_clk) pop_seen <= pop_flag;

   always @(negedge wb_clk) begin
      if (pop_seen) begin
         if (exp_data.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL wr_data: got 0x%0h, expected no word", bus.wr_data);
         end else begin
            check("wr_data", 32'(bus.wr_data), 32'(exp_data.pop_front()));
         end
      end
      if (bus.wr_en && !prev_en && !wb_rst) begin
         if (exp_addr.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL wr_req: got request at 0x%0h, expected none", bus.wr_addr);
         end else begin
            check("wr_addr", 32'(bus.wr_addr), 32'(exp_addr.pop_front()));
         end
         check("wr_bst_len", 32'(bus.wr_bst_len), 32'(BST_LEN));
      end
      prev_en = bus.wr_en;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.usr_wr_valid = 1'b0;
      bus.usr_wr_data  = '0;
      bus.wr_ack       = 1'b0;
      bus.wr_end       = 1'b0;
      repeat (2) @(posedge wb_clk);
      #1;
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("rst_addr", 32'(bus.wr_addr), 32'(ADDR_BASE));
      check("rst_data", 32'(bus.wr_data), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      wb_rst = 1'b0;
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      check("rst_ready", 32'(bus.usr_wr_ready), 32'd1);

      // Burst 1: words 0..255, request latency, address advance.
      init_end = 1'b1;
      for (int i = 0; i < 256; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      check("lat_0", 32'(bus.wr_en), 32'd0);
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      check("lat_1", 32'(bus.wr_en), 32'd1);
      do_burst(256, 0, -1);
      check("addr_1", 32'(bus.wr_addr), 32'h100);
      check("err_b1", 32'(err), 32'd0);
      check("level_b1", 32'(fifo_level), 32'd0);

      // Burst 2: no request until init_end, then 44 words left.
      init_end = 1'b0;
      for (int i = 0; i < 300; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      repeat (4) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      check("no_init_en", 32'(bus.wr_en), 32'd0);
      check("no_init_lvl", 32'(fifo_level), 32'd300);
      init_end = 1'b1;
      model_maybe_req();
      do_burst(256, 0, -1);
      check("level_44", 32'(fifo_level), 32'd44);

      // Fill to full, extra push ignored, then pop-with-push while full.
      init_end = 1'b0;
      while (mq.size() < FIFO_DEPTH) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      check("full_ready", 32'(bus.usr_wr_ready), 32'd0);
      check("full_level", 32'(fifo_level), 32'd1024);
      cycle(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
      check("full_extra", 32'(fifo_level), 32'd1024);
      init_end = 1'b1;
      model_maybe_req();
      do_burst(256, 2, -1);
      check("full_pop_push", 32'(fifo_level), 32'd1023);
      check("model_level", 32'(fifo_level), 32'(mq.size()));

      // Bursts 4 and 5 (wrap back to base), burst 6 with addr_clr mid-burst.
      do_burst(256, 1, -1);
      do_burst(256, 1, -1);
      do_burst(256, 1, 100);
      check("clr_base", 32'(bus.wr_addr), 32'(ADDR_BASE));
      check("err_clean", 32'(err), 32'd0);

      // Short burst flags err, which stays set.
      do_burst(255, 1, -1);
      check("err_short", 32'(err), 32'd1);
      repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      check("err_held", 32'(err), 32'd1);

      // Reset in the middle of a burst.
      wait_req();
      for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      check("drained", 32'(exp_data.size()), 32'd0);
      #2;
      wb_rst = 1'b1;
      #1;
      check("mrst_wr_en", 32'(bus.wr_en), 32'd0);
      check("mrst_addr", 32'(bus.wr_addr), 32'(ADDR_BASE));
      check("mrst_data", 32'(bus.wr_data), 32'd0);
      check("mrst_err", 32'(err), 32'd0);
      check("mrst_level", 32'(fifo_level), 32'd0);
      check("mrst_ready", 32'(bus.usr_wr_ready), 32'd1);
      mq.delete();
      exp_data.delete();
      exp_addr.delete();
      model_busy = 1'b0;
      model_clr  = 1'b0;
      model_addr = ADDR_BASE;
      @(posedge wb_clk);
      #1;
      wb_rst = 1'b0;

      // Ack with an empty FIFO.
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      check("pre_empty_err", 32'(err), 32'd0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      check("empty_ack_err", 32'(err), 32'd1);
      repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      check("empty_err_held", 32'(err), 32'd1);
      check("empty_level", 32'(fifo_level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
